ptmch_spi_cmd_gen: RTL

//  SPI mode-0 initiator on CLK160M that issues SPI-NAND instruction frames (opcode + 0..3 arg bytes + 0..2 read bytes).

---
 rtl/ptmch_spi_cmd_gen_if.sv | 22 ++
 rtl/ptmch_spi_cmd_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_spi_cmd_gen_if.sv
// Command/response bundle between a traffic source and ptmch_spi_cmd_gen.
// The generator sits on the slave side; the command source uses the master modport.
interface ptmch_spi_cmd_gen_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [23:0] cmd_arg;
    logic [1:0]  cmd_arg_len;
    logic [1:0]  cmd_rd_len;
    logic [15:0] rd_data;
    logic        done;

    modport master (
        output cmd_valid, cmd_opcode, cmd_arg, cmd_arg_len, cmd_rd_len,
        input  cmd_ready, rd_data, done
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_arg, cmd_arg_len, cmd_rd_len,
        output cmd_ready, rd_data, done
    );
endinterface

// File: rtl/ptmch_spi_cmd_gen.sv
// SPI mode-0 initiator issuing SPI-NAND frames: opcode, 0..3 argument bytes, 0..2 read bytes.
// Optional feature: define PTMCH_SPI_ABORT_EN to add abort_i, which cuts a frame short.
module ptmch_spi_cmd_gen #(
    parameter int unsigned ClkDiv  = 4,
    parameter int unsigned CsSetup = 4,
    parameter int unsigned CsHold  = 4,
    parameter int unsigned CsIdle  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
`ifdef PTMCH_SPI_ABORT_EN
    input  logic                      abort_i,
`endif
    ptmch_spi_cmd_gen_if.slave        cmd_if,
    input  logic                      spi_miso_i,
    output logic                      spi_cs_o,
    output logic                      spi_clk_o,
    output logic                      spi_mosi_o
);

    localparam int unsigned MaxAB  = (ClkDiv > CsSetup) ? ClkDiv : CsSetup;
    localparam int unsigned MaxCD  = (CsHold > CsIdle + 1) ? CsHold : CsIdle + 1;
    localparam int unsigned CntMax = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HalfEnd  = CntW'(ClkDiv - 1);
    localparam logic [CntW-1:0] SetupEnd = CntW'(CsSetup - 1);
    localparam logic [CntW-1:0] HoldEnd  = CntW'(CsHold - 1);
    // The CS-rise cycle is the first GAP cycle, so GAP spans CsIdle + 1 cycles.
    localparam logic [CntW-1:0] GapEnd   = CntW'(CsIdle);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      bit_q, bit_d;
    logic [5:0]      last_bit_q, last_bit_d;
    logic [5:0]      wr_bits_q, wr_bits_d;
    logic            rd_en_q, rd_en_d;
    logic [30:0]     tx_q, tx_d;
    logic [15:0]     rx_q, rx_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [15:0]     rd_data_q, rd_data_d;

    logic            abort;
    logic [1:0]      rd_eff;
    logic [2:0]      nbytes;
    logic [23:0]     arg_al;

`ifdef PTMCH_SPI_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign rd_eff = (cmd_if.cmd_rd_len == 2'd3) ? 2'd2 : cmd_if.cmd_rd_len;
    assign nbytes = 3'd1 + {1'b0, cmd_if.cmd_arg_len} + {1'b0, rd_eff};

    // Left-justify the used argument bytes so they follow the opcode out of one shifter.
    always_comb begin
        arg_al = 24'h0;
        case (cmd_if.cmd_arg_len)
            2'd0:    arg_al = 24'h0;
            2'd1:    arg_al = {cmd_if.cmd_arg[7:0], 16'h0};
            2'd2:    arg_al = {cmd_if.cmd_arg[15:0], 8'h0};
            default: arg_al = cmd_if.cmd_arg;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        wr_bits_d  = wr_bits_q;
        rd_en_d    = rd_en_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;

        if ((state_q == StSetup || state_q == StShift || state_q == StHold) && abort) begin
            state_d = StGap;
            cnt_d   = '0;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_if.cmd_valid && ready_q) begin
                        state_d    = StSetup;
                        cnt_d      = '0;
                        bit_d      = '0;
                        last_bit_d = {nbytes, 3'b000} - 6'd1;
                        wr_bits_d  = {3'd1 + {1'b0, cmd_if.cmd_arg_len}, 3'b000};
                        rd_en_d    = (rd_eff != 2'd0);
                        tx_d       = {cmd_if.cmd_opcode[6:0], arg_al};
                        rx_d       = '0;
                        cs_d       = 1'b0;
                        mosi_d     = cmd_if.cmd_opcode[7];
                        ready_d    = 1'b0;
                    end
                end
                StSetup: begin
                    if (cnt_q == SetupEnd) begin
                        state_d = StShift;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q != HalfEnd) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                            if (bit_q >= wr_bits_q) begin
                                rx_d = {rx_q[14:0], spi_miso_i};
                            end
                        end else begin
                            sclk_d = 1'b0;
                            if (bit_q == last_bit_q) begin
                                mosi_d  = 1'b0;
                                state_d = StHold;
                            end else begin
                                // Zero fill past the write bytes keeps MOSI low for read bytes.
                                bit_d  = bit_q + 6'd1;
                                mosi_d = tx_q[30];
                                tx_d   = {tx_q[29:0], 1'b0};
                            end
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == HoldEnd) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        if (rd_en_q) begin
                            rd_data_d = rx_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == GapEnd) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            wr_bits_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            wr_bits_q  <= wr_bits_d;
            rd_en_q    <= rd_en_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign spi_cs_o         = cs_q;
    assign spi_clk_o        = sclk_q;
    assign spi_mosi_o       = mosi_q;
    assign cmd_if.cmd_ready = ready_q;
    assign cmd_if.done      = done_q;
    assign cmd_if.rd_data   = rd_data_q;

endmodule
